// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
// Master drives operands and result-ready; slave is the datapath.
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             sub;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, ra, rb, sub, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow, zero
  );

  modport slave (
    input  in_valid, ra, rb, sub, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, overflow, zero
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined lookahead add/sub: one CHUNK-wide slice per register stage,
// carry rippling stage to stage, valid/ready with global stall.
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic                clock,
  input logic                clear,
  pipelined_addsub_if.slave  bus
);
  localparam int STAGES = WIDTH / CHUNK;

  logic              stall;
  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0]  bx;
  logic [WIDTH-1:0]  sum_q;
  logic              c_q;
  logic              ov_q;
  logic              z_q;

  // Returns {carry_out, sum} of one slice built from 4-bit g/p groups.
  function automatic logic [CHUNK:0] slice_add(
    input logic [CHUNK-1:0] a,
    input logic [CHUNK-1:0] b,
    input logic             ci
  );
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   c;
    g    = a & b;
    p    = a | b;
    c    = '0;
    c[0] = ci;
    for (int j = 0; j < CHUNK; j += 4) begin
      c[j+1] = g[j] | (p[j] & c[j]);
      c[j+2] = g[j+1] | (p[j+1] & g[j])
             | (p[j+1] & p[j] & c[j]);
      c[j+3] = g[j+2] | (p[j+2] & g[j+1])
             | (p[j+2] & p[j+1] & g[j])
             | (p[j+2] & p[j+1] & p[j] & c[j]);
      c[j+4] = g[j+3] | (p[j+3] & g[j+2])
             | (p[j+3] & p[j+2] & g[j+1])
             | (p[j+3] & p[j+2] & p[j+1] & g[j])
             | (&p[j+:4] & c[j]);
    end
    return {c[CHUNK], a ^ b ^ c[CHUNK-1:0]};
  endfunction

  assign stall         = vld[STAGES-1] && !bus.out_ready;
  assign bus.in_ready  = !stall;
  assign bus.out_valid = vld[STAGES-1];
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_q;
  assign bus.overflow  = ov_q;
  assign bus.zero      = z_q;

  assign bx = bus.sub ? ~bus.rb : bus.rb;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      vld <= '0;
    end else if (!stall) begin
      vld <= (vld << 1) | STAGES'(bus.in_valid);
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int RW = WIDTH - (k + 1) * CHUNK;

    logic [CHUNK-1:0]         a_s;
    logic [CHUNK-1:0]         b_s;
    logic                     ci;
    logic [CHUNK:0]           r;
    logic [(k+1)*CHUNK-1:0]   s_n;

    if (k == 0) begin : src
      assign a_s = bus.ra[CHUNK-1:0];
      assign b_s = bx[CHUNK-1:0];
      assign ci  = bus.sub | bus.c_in;
      assign s_n = r[CHUNK-1:0];
    end else begin : src
      assign a_s = stg[k-1].ops.a_q[CHUNK-1:0];
      assign b_s = stg[k-1].ops.b_q[CHUNK-1:0];
      assign ci  = stg[k-1].ops.cy_q;
      assign s_n = {r[CHUNK-1:0], stg[k-1].ops.s_q};
    end

    assign r = slice_add(a_s, b_s, ci);

    if (k < STAGES - 1) begin : ops
      logic [RW-1:0]          a_n;
      logic [RW-1:0]          b_n;
      logic [RW-1:0]          a_q;
      logic [RW-1:0]          b_q;
      logic [(k+1)*CHUNK-1:0] s_q;
      logic                   cy_q;

      if (k == 0) begin : nx
        assign a_n = bus.ra[WIDTH-1:CHUNK];
        assign b_n = bx[WIDTH-1:CHUNK];
      end else begin : nx
        assign a_n = stg[k-1].ops.a_q[RW+CHUNK-1:CHUNK];
        assign b_n = stg[k-1].ops.b_q[RW+CHUNK-1:CHUNK];
      end

      // Payload of bubbles is don't-care, so no reset here.
      always_ff @(posedge clock) begin
        if (!stall) begin
          a_q  <= a_n;
          b_q  <= b_n;
          s_q  <= s_n;
          cy_q <= r[CHUNK];
        end
      end
    end else begin : fin
      logic cmsb;

      // Carry into the MSB recovered from the sum bit itself.
      assign cmsb = a_s[CHUNK-1] ^ b_s[CHUNK-1] ^ r[CHUNK-1];

      always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
          sum_q <= '0;
          c_q   <= 1'b0;
          ov_q  <= 1'b0;
          z_q   <= 1'b0;
        end else if (!stall) begin
          sum_q <= s_n;
          c_q   <= r[CHUNK];
          ov_q  <= cmsb ^ r[CHUNK];
          z_q   <= (s_n == '0);
        end
      end
    end
  end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: default 32/8 and alternate 16/4 instances,
// arithmetic model queues plus hand-computed directed vectors.
module tb_pipelined_addsub;
  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        ov;
    logic        z;
  } res_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        ci;
    logic [31:0] es;
    logic        ec;
    logic        eov;
    logic        ez;
  } vec_t;

  logic clock;
  logic clear;
  int   nvec;
  int   nmis;
  res_t q32[$];
  res_t q16[$];

  pipelined_addsub_if #(.WIDTH(32)) b32();
  pipelined_addsub_if #(.WIDTH(16)) b16();

  pipelined_addsub #(.WIDTH(32), .CHUNK(8)) d32 (
    .clock(clock),
    .clear(clear),
    .bus  (b32.slave)
  );

  pipelined_addsub #(.WIDTH(16), .CHUNK(4)) d16 (
    .clock(clock),
    .clear(clear),
    .bus  (b16.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic res_t model(input int w, input logic [31:0] a,
                                 input logic [31:0] b, input logic s,
                                 input logic ci);
    logic [63:0] m;
    logic [63:0] bb;
    logic [63:0] t;
    res_t        r;
    m    = (64'd1 << w) - 64'd1;
    bb   = (s ? {32'h0, ~b} : {32'h0, b}) & m;
    t    = {32'h0, a} + bb + {63'h0, s | ci};
    r.s  = t[31:0] & m[31:0];
    r.c  = t[w];
    r.ov = (a[w-1] == bb[w-1]) && (t[w-1] != a[w-1]);
    r.z  = (r.s == 32'h0);
    return r;
  endfunction

  always @(negedge clock) begin
    if (clear) begin
      q32.delete();
    end else begin
      chk("rdy32", b32.in_ready, !(b32.out_valid && !b32.out_ready));
      if (b32.out_valid) begin
        if (q32.size() == 0) begin
          chk("spurious32", 1, 0);
        end else begin
          chk("res32", {b32.sum, b32.c_out, b32.overflow, b32.zero}, q32[0]);
          if (b32.out_ready) void'(q32.pop_front());
        end
      end
      if (b32.in_valid && b32.in_ready)
        q32.push_back(model(32, b32.ra, b32.rb, b32.sub, b32.c_in));
    end
  end

  always @(negedge clock) begin
    if (clear) begin
      q16.delete();
    end else begin
      chk("rdy16", b16.in_ready, !(b16.out_valid && !b16.out_ready));
      if (b16.out_valid) begin
        if (q16.size() == 0) begin
          chk("spurious16", 1, 0);
        end else begin
          chk("res16", {16'h0, b16.sum, b16.c_out, b16.overflow, b16.zero},
              q16[0]);
          if (b16.out_ready) void'(q16.pop_front());
        end
      end
      if (b16.in_valid && b16.in_ready)
        q16.push_back(model(16, {16'h0, b16.ra}, {16'h0, b16.rb},
                            b16.sub, b16.c_in));
    end
  end

  task automatic drive(input bit w16, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic s, input logic ci);
    if (w16) begin
      b16.in_valid = v;
      b16.ra       = a[15:0];
      b16.rb       = b[15:0];
      b16.sub      = s;
      b16.c_in     = ci;
    end else begin
      b32.in_valid = v;
      b32.ra       = a;
      b32.rb       = b;
      b32.sub      = s;
      b32.c_in     = ci;
    end
  endtask

  task automatic snap(input bit w16, output logic v, output logic [31:0] s,
                      output logic c, output logic o, output logic z);
    if (w16) begin
      v = b16.out_valid;
      s = {16'h0, b16.sum};
      c = b16.c_out;
      o = b16.overflow;
      z = b16.zero;
    end else begin
      v = b32.out_valid;
      s = b32.sum;
      c = b32.c_out;
      o = b32.overflow;
      z = b32.zero;
    end
  endtask

  // One isolated beat: checks exact latency and literal results.
  task automatic single(input bit w16, input vec_t t);
    logic        v;
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
    @(posedge clock);
    #1;
    drive(w16, 1'b1, t.a, t.b, t.s, t.ci);
    @(posedge clock);
    #1;
    drive(w16, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      snap(w16, v, s, c, o, z);
      chk("lat_early", v, 0);
    end
    @(negedge clock);
    snap(w16, v, s, c, o, z);
    chk("lat_valid", v, 1);
    chk("dir_sum", s, t.es);
    chk("dir_flags", {c, o, z}, {t.ec, t.eov, t.ez});
  endtask

  vec_t v32[6];
  vec_t v16[3];
  logic [31:0] got[8];

  initial begin
    nvec = 0;
    nmis = 0;
    clear = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    b32.out_ready = 1'b1;
    b16.out_ready = 1'b1;

    v32[0] = '{32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1};
    v32[1] = '{32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    v32[2] = '{32'h80000000, 32'h1, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    v32[3] = '{32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    v32[4] = '{32'h7, 32'h7, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1};
    v32[5] = '{32'h1, 32'h2, 1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0};
    v16[0] = '{32'hFFFF, 32'h1, 1'b0, 1'b1, 32'h1, 1'b1, 1'b0, 1'b0};
    v16[1] = '{32'h0FFF, 32'h1, 1'b0, 1'b0, 32'h1000, 1'b0, 1'b0, 1'b0};
    v16[2] = '{32'hFFFF, 32'h1, 1'b1, 1'b0, 32'hFFFE, 1'b1, 1'b0, 1'b0};

    repeat (2) @(negedge clock);
    chk("rst_valid", b32.out_valid, 0);
    chk("rst_sum", b32.sum, 0);
    chk("rst_flags", {b32.c_out, b32.overflow, b32.zero}, 0);
    chk("rst_ready", b32.in_ready, 1);
    @(posedge clock);
    #1 clear = 1'b0;

    foreach (v32[i]) single(1'b0, v32[i]);
    foreach (v16[i]) single(1'b1, v16[i]);

    // Streaming with a 3-cycle backpressure window.
    @(posedge clock);
    #1;
    fork
      begin
        for (int i = 1; i <= 8; i++) begin
          int t;
          bit acc;
          t   = 0;
          acc = 1'b0;
          drive(1'b0, 1'b1, i, 32'h100 * i, 1'b0, 1'b0);
          while (!acc && t < 50) begin
            @(negedge clock);
            acc = b32.in_ready;
            @(posedge clock);
            #1;
            t++;
          end
          chk("prod_timeout", acc, 1);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      end
      begin
        int  n;
        bit  ds;
        n  = 0;
        ds = 1'b0;
        for (int t = 0; t < 200 && n < 8; t++) begin
          @(negedge clock);
          if (b32.out_valid && b32.out_ready) begin
            got[n] = b32.sum;
            n++;
          end
          if (n == 2 && !ds) begin
            ds = 1'b1;
            @(posedge clock);
            #1 b32.out_ready = 1'b0;
            repeat (3) begin
              @(negedge clock);
              chk("stall_in_ready", b32.in_ready, 0);
              chk("stall_hold", b32.sum, 32'h303);
            end
            @(posedge clock);
            #1 b32.out_ready = 1'b1;
          end
        end
        chk("stream_count", n, 8);
      end
    join
    for (int i = 0; i < 8; i++) chk("stream_order", got[i], 32'h101 * (i + 1));

    // Clear while three beats are in flight.
    repeat (6) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'h10 + i, 32'h1, 1'b0, 1'b0);
      @(posedge clock);
      #1;
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    clear = 1'b1;
    #1;
    chk("clr_async", b32.out_valid, 0);
    @(posedge clock);
    #1 clear = 1'b0;
    repeat (6) begin
      @(negedge clock);
      chk("clr_no_stale", b32.out_valid, 0);
    end
    single(1'b0, '{32'h2, 32'h3, 1'b0, 1'b0, 32'h5, 1'b0, 1'b0, 1'b0});

    repeat (6) @(negedge clock);
    chk("drain32", q32.size(), 0);
    chk("drain16", q16.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
